// File: rtl/mfccs13_ram_pkg.sv
// Shared constants and FSM encoding for the MFCC coefficient recorder.
package mfccs13_ram_pkg;

  localparam int unsigned ADDR_W       = 13;
  localparam int unsigned DATA_W       = 14;
  localparam int unsigned NCOEF        = 13;
  localparam int unsigned FRAME_STRIDE = 16;
  localparam int unsigned STRIDE_BITS  = $clog2(FRAME_STRIDE);
  localparam int unsigned MAX_FRAMES   = 512;
  localparam int unsigned FRAME_CNT_W  = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REC  = 2'd1,
    DONE = 2'd2
  } rec_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered priority pointer.
module rr_arb2
  import mfccs13_ram_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic ptr;

  always_comb begin
    gnt = '0;
    if (!ptr) begin
      if (req[0])      gnt[0] = 1'b1;
      else if (req[1]) gnt[1] = 1'b1;
    end else begin
      if (req[1])      gnt[1] = 1'b1;
      else if (req[0]) gnt[0] = 1'b1;
    end
  end

  // Priority moves to the requester that was not just served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ptr <= 1'b0;
    else if (gnt[0]) ptr <= 1'b1;
    else if (gnt[1]) ptr <= 1'b0;
  end

endmodule

// File: rtl/mfccs13_ram_ctrl.sv
// Records framed MFCC coefficients into RAM and serves two round-robin read ports.
module mfccs13_ram_ctrl #(
  parameter int unsigned ADDR_W = mfccs13_ram_pkg::ADDR_W,
  parameter int unsigned DATA_W = mfccs13_ram_pkg::DATA_W,
  parameter int unsigned NCOEF  = mfccs13_ram_pkg::NCOEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              coef_valid,
  input  logic              coef_last,
  input  logic [DATA_W-1:0] coef_data,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data,
  input  logic              rq0_req,
  input  logic              rq1_req,
  input  logic [ADDR_W-1:0] rq0_addr,
  input  logic [ADDR_W-1:0] rq1_addr,
  output logic              rq0_gnt,
  output logic              rq1_gnt,
  output logic [1:0]        rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rec_busy,
  output logic              rec_done,
  output logic [9:0]        frame_cnt,
  output logic              frame_err,
  output logic              overflow
);

  import mfccs13_ram_pkg::rec_state_t;
  import mfccs13_ram_pkg::IDLE;
  import mfccs13_ram_pkg::REC;
  import mfccs13_ram_pkg::DONE;
  import mfccs13_ram_pkg::STRIDE_BITS;
  import mfccs13_ram_pkg::MAX_FRAMES;
  import mfccs13_ram_pkg::FRAME_CNT_W;

  localparam int unsigned FB = ADDR_W - STRIDE_BITS;
  localparam logic [STRIDE_BITS-1:0] LAST_IDX = STRIDE_BITS'(NCOEF - 1);
  localparam logic [FRAME_CNT_W-1:0] LAST_FRAME = FRAME_CNT_W'(MAX_FRAMES - 1);

  rec_state_t             state;
  logic [STRIDE_BITS-1:0] idx;
  logic                   at_last;
  logic [1:0]             gnt;

  assign at_last  = (idx == LAST_IDX);
  assign rec_busy = (state == REC);
  assign rec_done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      frame_cnt   <= '0;
      idx         <= '0;
      frame_err   <= 1'b0;
      overflow    <= 1'b0;
      ram_wr_en   <= 1'b0;
      ram_wr_addr <= '0;
      ram_wr_data <= '0;
    end else begin
      ram_wr_en <= 1'b0;
      if (start) begin
        state     <= REC;
        frame_cnt <= '0;
        idx       <= '0;
        frame_err <= 1'b0;
        overflow  <= 1'b0;
      end else begin
        case (state)
          REC: begin
            if (stop) begin
              state <= DONE;
              idx   <= '0;
            end else if (coef_valid) begin
              ram_wr_en   <= 1'b1;
              ram_wr_addr <= {frame_cnt[FB-1:0], idx};
              ram_wr_data <= coef_data;
              // A badly framed coefficient is still written; the slot is reused by the next frame.
              if (at_last && coef_last) begin
                idx       <= '0;
                frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
                if (frame_cnt == LAST_FRAME) state <= DONE;
              end else if (at_last || coef_last) begin
                frame_err <= 1'b1;
                idx       <= '0;
              end else begin
                idx <= idx + STRIDE_BITS'(1);
              end
            end
          end
          DONE: if (coef_valid) overflow <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({rq1_req, rq0_req}),
    .gnt   (gnt)
  );

  assign rq0_gnt     = gnt[0];
  assign rq1_gnt     = gnt[1];
  assign ram_rd_addr = gnt[1] ? rq1_addr : rq0_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_valid <= '0;
    else        rd_valid <= gnt;
  end

  // RAM data arrives the cycle after the grant, aligned with rd_valid.
  assign rd_data = (rd_valid != 2'b00) ? ram_rd_data : '0;

endmodule

// File: tb/tb_mfccs13_ram_ctrl.sv
// Directed bench for mfccs13_ram_ctrl with a behavioural 1-cycle-latency RAM.
`timescale 1ns/1ps
module tb_mfccs13_ram_ctrl;

  localparam int unsigned AW = 13;
  localparam int unsigned DW = 14;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, stop, coef_valid, coef_last;
  logic [DW-1:0] coef_data;
  logic          ram_wr_en;
  logic [AW-1:0] ram_wr_addr, ram_rd_addr;
  logic [DW-1:0] ram_wr_data, ram_rd_data, rd_data;
  logic          rq0_req, rq1_req, rq0_gnt, rq1_gnt;
  logic [AW-1:0] rq0_addr, rq1_addr;
  logic [1:0]    rd_valid;
  logic          rec_busy, rec_done, frame_err, overflow;
  logic [9:0]    frame_cnt;

  logic [DW-1:0] mem [0:(1<<AW)-1] = '{default: 14'h2AAA};
  int unsigned   wr_count = 0;
  int unsigned   checks = 0;
  int unsigned   failures = 0;
  int unsigned   snap;

  always #5 clk = ~clk;

  mfccs13_ram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .NCOEF(13)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .coef_valid(coef_valid), .coef_last(coef_last), .coef_data(coef_data),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .rq0_req(rq0_req), .rq1_req(rq1_req), .rq0_addr(rq0_addr), .rq1_addr(rq1_addr),
    .rq0_gnt(rq0_gnt), .rq1_gnt(rq1_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .rec_busy(rec_busy), .rec_done(rec_done), .frame_cnt(frame_cnt),
    .frame_err(frame_err), .overflow(overflow)
  );

  always @(posedge clk) begin
    if (ram_wr_en) begin
      mem[ram_wr_addr] <= ram_wr_data;
      wr_count         <= wr_count + 1;
    end
    ram_rd_data <= mem[ram_rd_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_coef(input logic [DW-1:0] d, input logic last);
    coef_valid = 1'b1;
    coef_data  = d;
    coef_last  = last;
    tick();
    coef_valid = 1'b0;
    coef_last  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_frame(input int unsigned base);
    for (int unsigned c = 0; c < 13; c++)
      send_coef(DW'(base + c), c == 12);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    coef_valid = 1'b0; coef_last = 1'b0; coef_data = '0;
    rq0_req = 1'b0; rq1_req = 1'b0; rq0_addr = '0; rq1_addr = '0;
    #12;
    check_eq("rst_wr_en", ram_wr_en, 0);
    check_eq("rst_wr_addr", ram_wr_addr, 0);
    check_eq("rst_rd_valid", rd_valid, 0);
    check_eq("rst_status", {rec_busy, rec_done, frame_err, overflow}, 0);
    check_eq("rst_frame_cnt", frame_cnt, 0);
    rst_n = 1'b1;
    tick();

    // Three clean frames, data = 100*f + c.
    pulse_start();
    check_eq("start_busy", rec_busy, 1);
    snap = wr_count;
    for (int unsigned f = 0; f < 3; f++) begin
      for (int unsigned c = 0; c < 13; c++) begin
        send_coef(DW'(100 * f + c), c == 12);
        if (f == 0 && c == 0)
          check_eq("first_write", {ram_wr_en, ram_wr_addr, ram_wr_data}, {1'b1, 13'h000, 14'd0});
      end
    end
    tick();
    check_eq("frames3_cnt", frame_cnt, 3);
    check_eq("frames3_writes", wr_count - snap, 39);
    check_eq("mem_000", mem[13'h000], 0);
    check_eq("mem_00C", mem[13'h00C], 12);
    check_eq("mem_010", mem[13'h010], 100);
    check_eq("mem_01C", mem[13'h01C], 112);
    check_eq("mem_02C", mem[13'h02C], 212);
    check_eq("mem_00D_unused", mem[13'h00D], 14'h2AAA);

    // coef_last arriving at index 5 is a framing error; slot 3 is then reused.
    for (int unsigned c = 0; c < 6; c++) send_coef(DW'(300 + c), c == 5);
    check_eq("ferr_flag", frame_err, 1);
    check_eq("ferr_cnt", frame_cnt, 3);
    send_frame(400);
    tick();
    check_eq("ferr_next_cnt", frame_cnt, 4);
    check_eq("mem_030", mem[13'h030], 400);
    check_eq("mem_03C", mem[13'h03C], 412);
    check_eq("mem_035", mem[13'h035], 405);
    check_eq("ferr_sticky", frame_err, 1);

    // Round-robin reads after reset.
    do_reset();
    check_eq("rst2_frame_err", frame_err, 0);
    rq0_req = 1'b1; rq1_req = 1'b1;
    rq0_addr = 13'h005; rq1_addr = 13'h01C;
    for (int unsigned k = 0; k < 4; k++) begin
      #1;
      check_eq("arb_gnt", {rq1_gnt, rq0_gnt}, (k % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      if (k == 3) begin rq0_req = 1'b0; rq1_req = 1'b0; end
      check_eq("arb_rd_valid", rd_valid, (k % 2 == 0) ? 2'b01 : 2'b10);
      check_eq("arb_rd_data", rd_data, (k % 2 == 0) ? 5 : 112);
    end
    tick();
    check_eq("arb_idle", rd_valid, 0);
    rq1_req = 1'b1;
    #1;
    check_eq("arb_lone_gnt0", {rq1_gnt, rq0_gnt}, 2'b10);
    tick();
    check_eq("arb_lone_gnt1", {rq1_gnt, rq0_gnt}, 2'b10);
    rq1_req = 1'b0;
    tick();

    // Stop mid-frame discards the partial frame.
    pulse_start();
    send_frame(0);
    send_frame(13);
    for (int unsigned c = 0; c < 7; c++) send_coef(DW'(c), 1'b0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_eq("stop_done", {rec_busy, rec_done}, 2'b01);
    check_eq("stop_cnt", frame_cnt, 2);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_eq("stop_in_done", {rec_done, frame_cnt}, {1'b1, 10'd2});
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check_eq("start_over_stop", {rec_busy, frame_cnt}, {1'b1, 10'd0});

    // Reset during frame 4 of a recording.
    send_frame(0); send_frame(0); send_frame(0); send_frame(0);
    for (int unsigned c = 0; c < 3; c++) send_coef(DW'(c), 1'b0);
    coef_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    check_eq("rstmid_outs", {ram_wr_en, ram_wr_addr, ram_wr_data, rd_valid, rd_data}, 0);
    check_eq("rstmid_status", {rec_busy, rec_done, frame_err, overflow, frame_cnt}, 0);
    tick();
    #3;
    rst_n = 1'b1;
    snap = wr_count;
    for (int unsigned k = 0; k < 3; k++) begin
      tick();
      check_eq("rstmid_no_wr", ram_wr_en, 0);
    end
    check_eq("rstmid_wr_count", wr_count - snap, 0);
    check_eq("rstmid_idle", {rec_busy, rec_done}, 0);
    coef_valid = 1'b0;

    // Fill all 512 frame slots, then overrun.
    pulse_start();
    for (int unsigned f = 0; f < 512; f++) send_frame(f * 13);
    check_eq("full_cnt", frame_cnt, 512);
    check_eq("full_done", {rec_busy, rec_done}, 2'b01);
    tick();
    check_eq("mem_1FFC", mem[13'h1FFC], 6655);
    check_eq("mem_1000", mem[13'h1000], 256 * 13);
    snap = wr_count;
    send_coef(14'h0123, 1'b0);
    check_eq("ovf_no_wr", ram_wr_en, 0);
    check_eq("ovf_flag", overflow, 1);
    tick();
    check_eq("ovf_wr_count", wr_count - snap, 0);
    pulse_start();
    check_eq("restart_clear", {overflow, frame_cnt, rec_busy}, {1'b0, 10'd0, 1'b1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mfccs13_ram_ctrl.md
MFCCS13_RAM_CTRL -- requirements
Module: mfccs13_ram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, meaning the RAM address width.
REQ-002 SHALL have parameter DATA_W, default 14, meaning the coefficient and RAM data width.
REQ-003 SHALL have parameter NCOEF, default 13, meaning the number of coefficients per frame.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port start, input, 1 bit: pulse that begins a new recording.
REQ-007 SHALL have port stop, input, 1 bit: pulse that ends a recording.
REQ-008 SHALL have ports coef_valid (input, 1), coef_last (input, 1) and coef_data (input, DATA_W): the coefficient stream; coef_last marks the 13th coefficient.
REQ-009 SHALL have ports ram_wr_en (output, 1), ram_wr_addr (output, ADDR_W) and ram_wr_data (output, DATA_W): the RAM write port.
REQ-010 SHALL have ports ram_rd_addr (output, ADDR_W) and ram_rd_data (input, DATA_W): the RAM read port, unregistered output with 1-cycle read latency.
REQ-011 SHALL have ports rq0_req / rq1_req (input, 1), rq0_addr / rq1_addr (input, ADDR_W) and rq0_gnt / rq1_gnt (output, 1): the two read requesters.
REQ-012 SHALL have ports rd_valid (output, 2) and rd_data (output, DATA_W): read return, with one-hot rd_valid identifying the requester.
REQ-013 SHALL have status outputs:
- rec_busy (1)
- rec_done (1)
- frame_cnt (10): committed frames
- frame_err (1): sticky
- overflow (1): sticky

Function
REQ-014 SHALL store frame f, coefficient c at address {f[8:0], c[3:0]}; the frame stride is 16 and slots 13-15 are never written.
REQ-015 SHALL implement FSM states IDLE, REC and DONE.
REQ-016 SHALL handle start from any state as follows:
- go to REC
- clear frame_cnt, the coefficient index, frame_err and overflow
- start takes priority over a simultaneous stop
REQ-017 SHALL, in REC, on each coef_valid, assert ram_wr_en for that same cycle, with address per REQ-014 and the data registered from coef_data, then increment the coefficient index.
REQ-018 SHALL commit a frame when a coefficient with coef_last=1 arrives at index 12: frame_cnt increments by 1 and the index returns to 0.
REQ-019 SHALL treat coef_last at index <12, or index 12 without coef_last, as a framing error:
- set frame_err
- write the coefficient but do not commit the frame
- reset the index to 0
REQ-020 SHALL go to DONE when frame_cnt reaches 512; coef_valid in DONE or IDLE performs no write, and in DONE it sets overflow.
REQ-021 SHALL handle stop in REC as follows: discard any partial frame (frame_cnt unchanged) and go to DONE; stop in IDLE or DONE has no effect.
REQ-022 SHALL drive rec_busy=1 exactly in REC and rec_done=1 exactly in DONE.
REQ-023 SHALL arbitrate reads round-robin at one grant per cycle:
- gnt is combinational from req and the priority pointer
- the pointer moves to the other requester after a grant
- a lone requester is granted every cycle
REQ-024 SHALL drive ram_rd_addr from the granted requester's address; rd_valid[i] SHALL assert exactly 1 cycle after rq_i_gnt, with rd_data = ram_rd_data.
REQ-025 SHALL serve reads independently of the write FSM: no address range check, and no forwarding of a same-address same-cycle write (old data is returned).

Reset
REQ-026 SHALL, while rst_n=0, asynchronously set:
- state to IDLE
- frame_cnt and the coefficient index to 0
- frame_err, overflow, ram_wr_en, rd_valid, rd_data, ram_wr_addr and ram_wr_data to 0
- the priority pointer to requester 0
REQ-027 SHALL cause reset asserted mid-recording to lose all committed frame status, with no RAM write on the cycle reset releases.

Structure
REQ-028 SHALL place ADDR_W, DATA_W, NCOEF, the frame stride (16), MAX_FRAMES (512) and the FSM state encoding in the shared package mfccs13_ram_pkg.
REQ-029 SHALL implement the read arbiter as the sub-module rr_arb2, which has 2 requests, 2 grants and a registered pointer.

Verification
REQ-030 SHALL cover frame write: start, then 3 frames of 13 coefficients with data = 100*f+c -> writes at addresses 0x000-0x00C, 0x010-0x01C and 0x020-0x02C; frame_cnt=3.
REQ-031 SHALL cover framing error: coef_last at index 5 -> frame_err=1 and frame_cnt unchanged; the next full frame commits at the same frame slot.
REQ-032 SHALL cover the full boundary: 512 frames -> DONE, rec_done=1; one more coef_valid -> no write and overflow=1.
REQ-033 SHALL cover read arbitration: rq0_req and rq1_req both held for 4 cycles after reset -> grants 0,1,0,1; rd_valid alternates 2'b01/2'b10 one cycle later with matching data.
REQ-034 SHALL cover stop mid-frame: stop after 7 coefficients of frame 2 -> DONE with frame_cnt=2; start then clears frame_cnt to 0.
REQ-035 SHALL cover reset mid-record: rst_n low during frame 4 -> all outputs 0 and state IDLE; coef_valid after release causes no writes.
